// File: rtl/multiplexer_struct_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplexer_struct_sync_if
// Description : Bus bundle for the structural 2:1 mux. The master drives
//               select/data, the slave returns the combinational and
//               registered mux results.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplexer_struct_sync_if #(
    parameter int WIDTH = 1
);
    logic             x;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;

    modport master (
        output x,
        output u,
        output v,
        input  z,
        input  z_q
    );

    modport slave (
        input  x,
        input  u,
        input  v,
        output z,
        output z_q
    );
endinterface
`default_nettype wire

// File: rtl/multiplexer_struct_sync.sv
`default_nettype none
// ============================================================================
// Module      : multiplexer_struct_sync
// Description : Gate-level 2:1 multiplexer (x=1 -> u, x=0 -> v) with a
//               hazard-free consensus term and a registered copy of the
//               result. The data path uses NOT/AND/OR primitives only.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplexer_struct_sync #(
    parameter int WIDTH = 1
) (
    input  wire                       clk,
    input  wire                       rst_n,
    multiplexer_struct_sync_if.slave  bus
);

    wire             w_x;
    wire             w_x_n;
    wire [WIDTH-1:0] w_u;
    wire [WIDTH-1:0] w_v;
    wire [WIDTH-1:0] w_z;

    logic [WIDTH-1:0] z_q_d;
    logic [WIDTH-1:0] z_q_q;

    assign w_x = bus.x;
    assign w_u = bus.u;
    assign w_v = bus.v;

    // Inverted select is shared by every bit slice.
    not u_sel_inv (w_x_n, w_x);

    // Per-bit slice: z = x&u | ~x&v | u&v. The u&v consensus term keeps the
    // output high while x switches with u=v=1, and also resolves an unknown
    // select whenever both data inputs agree.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            wire w_sel_u;
            wire w_sel_v;
            wire w_cons;

            and u_and_u (w_sel_u, w_x,   w_u[i]);
            and u_and_v (w_sel_v, w_x_n, w_v[i]);
            and u_and_c (w_cons,  w_u[i], w_v[i]);
            or  u_or    (w_z[i],  w_sel_u, w_sel_v, w_cons);
        end
    endgenerate

    // Next value of the output register is simply the current mux result.
    always_comb begin
        z_q_d = w_z;
    end

    // Output register: cleared immediately on reset, samples z every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q_q <= '0;
        end else begin
            z_q_q <= z_q_d;
        end
    end

    assign bus.z   = w_z;
    assign bus.z_q = z_q_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplexer_struct_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplexer_struct_sync
// Description : Directed self-checking bench for multiplexer_struct_sync,
//               exercising a 1-bit and an 8-bit instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexer_struct_sync;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;
    int glitches;
    bit win;

    multiplexer_struct_sync_if #(.WIDTH(1)) bus1 ();
    multiplexer_struct_sync_if #(.WIDTH(8)) bus8 ();

    multiplexer_struct_sync #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    multiplexer_struct_sync #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any change of the 1-bit output to a non-1 value inside the window counts.
    always @(bus1.z) begin
        if (win && bus1.z !== 1'b1) glitches++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic x, input logic u, input logic v);
        bus1.x = x;
        bus1.u = u;
        bus1.v = v;
    endtask

    task automatic drv8(input logic x, input logic [7:0] u, input logic [7:0] v);
        bus8.x = x;
        bus8.u = u;
        bus8.v = v;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        glitches = 0;
        win      = 1'b0;

        // Reset held: register stays zero, combinational path still live.
        rst_n = 1'b0;
        drv1(1'b1, 1'b1, 1'b0);
        drv8(1'b1, 8'hA5, 8'h3C);
        @(posedge clk); #1;
        chk("rst_z1",   {7'd0, bus1.z},   8'h01);
        chk("rst_zq1",  {7'd0, bus1.z_q}, 8'h00);
        chk("rst_z8",   bus8.z,           8'hA5);
        chk("rst_zq8",  bus8.z_q,         8'h00);

        // Release between edges: register holds zero until the next edge.
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_zq1_hold", {7'd0, bus1.z_q}, 8'h00);
        @(posedge clk); #1;
        chk("rel_zq1_load", {7'd0, bus1.z_q}, 8'h01);
        chk("rel_zq8_load", bus8.z_q,         8'hA5);

        // x=1 selects u.
        @(negedge clk); drv1(1'b1, 1'b0, 1'b0); #1;
        chk("x1_u0_v0", {7'd0, bus1.z}, 8'h00);
        @(posedge clk); #1;
        chk("x1_u0_v0_q", {7'd0, bus1.z_q}, 8'h00);
        @(negedge clk); drv1(1'b1, 1'b1, 1'b0); #1;
        chk("x1_u1_v0", {7'd0, bus1.z}, 8'h01);
        chk("x1_u1_v0_qlag", {7'd0, bus1.z_q}, 8'h00);
        @(posedge clk); #1;
        chk("x1_u1_v0_q", {7'd0, bus1.z_q}, 8'h01);

        // v ignored when x=1, then selected when x=0.
        @(negedge clk); drv1(1'b1, 1'b0, 1'b1); #1;
        chk("x1_u0_v1", {7'd0, bus1.z}, 8'h00);
        chk("x1_u0_v1_qlag", {7'd0, bus1.z_q}, 8'h01);
        @(posedge clk); #1;
        chk("x1_u0_v1_q", {7'd0, bus1.z_q}, 8'h00);
        @(negedge clk); drv1(1'b0, 1'b0, 1'b1); #1;
        chk("x0_u0_v1", {7'd0, bus1.z}, 8'h01);
        @(posedge clk); #1;
        chk("x0_u0_v1_q", {7'd0, bus1.z_q}, 8'h01);
        @(negedge clk); drv1(1'b0, 1'b1, 1'b0); #1;
        chk("x0_u1_v0", {7'd0, bus1.z}, 8'h00);

        // u=v=1 with x toggling: output must never leave 1.
        @(negedge clk); drv1(1'b1, 1'b1, 1'b1); #1;
        chk("uv1_start", {7'd0, bus1.z}, 8'h01);
        win = 1'b1;
        #20 bus1.x = 1'b0;
        #20 bus1.x = 1'b1;
        #20 bus1.x = 1'b0;
        #20 bus1.x = 1'b1;
        #1;
        win = 1'b0;
        chk("uv1_glitches", glitches[7:0], 8'h00);
        chk("uv1_z",  {7'd0, bus1.z},   8'h01);
        chk("uv1_zq", {7'd0, bus1.z_q}, 8'h01);

        // Unknown select with agreeing data inputs resolves to the data.
        bus1.x = 1'bx; #1;
        chk("xsel_uv1", {7'd0, bus1.z}, 8'h01);
        bus1.u = 1'b0; bus1.v = 1'b0; #1;
        chk("xsel_uv0", {7'd0, bus1.z}, 8'h00);

        // 8-bit data path.
        @(negedge clk); drv8(1'b1, 8'hA5, 8'h3C); #1;
        chk("w8_x1", bus8.z, 8'hA5);
        @(posedge clk); #1;
        chk("w8_x1_q", bus8.z_q, 8'hA5);
        @(negedge clk); bus8.x = 1'b0; #1;
        chk("w8_x0", bus8.z, 8'h3C);
        chk("w8_x0_qlag", bus8.z_q, 8'hA5);
        @(posedge clk); #1;
        chk("w8_x0_q", bus8.z_q, 8'h3C);
        @(negedge clk); drv8(1'b1, 8'hF0, 8'h0F); #1;
        chk("w8_f0", bus8.z, 8'hF0);
        bus8.x = 1'b0; #1;
        chk("w8_0f", bus8.z, 8'h0F);

        // Reset asserted between edges while z=1.
        @(negedge clk); drv1(1'b1, 1'b1, 1'b0); drv8(1'b1, 8'h5A, 8'h00);
        @(posedge clk); #1;
        chk("pre_rst_zq1", {7'd0, bus1.z_q}, 8'h01);
        chk("pre_rst_zq8", bus8.z_q,         8'h5A);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("mid_rst_zq1", {7'd0, bus1.z_q}, 8'h00);
        chk("mid_rst_zq8", bus8.z_q,         8'h00);
        chk("mid_rst_z1",  {7'd0, bus1.z},   8'h01);
        #1 rst_n = 1'b1; #1;
        chk("mid_rel_zq1", {7'd0, bus1.z_q}, 8'h00);
        @(posedge clk); #1;
        chk("post_rel_zq1", {7'd0, bus1.z_q}, 8'h01);
        chk("post_rel_zq8", bus8.z_q,         8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
